// File: rtl/env_pkg.sv
// Shared types, rate table and step-period helper for the envelope scheduler.
package env_pkg;

  typedef enum logic [2:0] {
    EnvIdle,
    EnvAttack,
    EnvDecay,
    EnvSustain,
    EnvRelease
  } env_state_t;

  typedef enum logic {
    SchedWait,
    SchedService
  } sched_state_t;

  localparam int unsigned RATE_TABLE [16] = '{
    2000, 8000, 16000, 24000, 38000, 56000, 68000, 80000,
    100000, 250000, 500000, 800000, 1000000, 3000000, 5000000, 8000000
  };

  // Decay and release run three times slower than attack for the same nibble.
  function automatic int unsigned step_period(env_state_t st, logic [15:0] adsr,
                                              int unsigned shift);
    int unsigned base;
    int unsigned per;
    case (st)
      EnvAttack: base = RATE_TABLE[adsr[15:12]];
      EnvDecay:  base = 3 * RATE_TABLE[adsr[11:8]];
      default:   base = 3 * RATE_TABLE[adsr[3:0]];
    endcase
    per = base >> shift;
    if (per == 0) per = 1;
    return per;
  endfunction

endpackage

// File: rtl/env_scheduler_if.sv
// Control/status bundle between the envelope scheduler and its host.
interface env_scheduler_if #(
  parameter int unsigned NUM_VOICES = 3
);
  logic                      tick_en;
  logic [NUM_VOICES*8-1:0]   control_v;
  logic [NUM_VOICES*16-1:0]  adsr_v;
  logic [NUM_VOICES*8-1:0]   vol_out;
  logic                      busy;
  logic                      round_done;
  logic                      overrun;

  modport master (
    output tick_en, control_v, adsr_v,
    input  vol_out, busy, round_done, overrun
  );

  modport slave (
    input  tick_en, control_v, adsr_v,
    output vol_out, busy, round_done, overrun
  );
endinterface

// File: rtl/env_step.sv
// Combinational next-state for one voice: TEST, then gate edges, then rate stepping.
module env_step
  import env_pkg::*;
#(
  parameter int unsigned CNT_W        = 25,
  parameter int unsigned PERIOD_SHIFT = 0
) (
  input  env_state_t       st,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       lvl,
  input  logic             prev_gate,
  input  logic             gate,
  input  logic             test,
  input  logic [15:0]      adsr,
  output env_state_t       st_next,
  output logic [CNT_W-1:0] cnt_next,
  output logic [7:0]       lvl_next
);

  int unsigned period;
  logic [32:0] cnt_inc;
  logic        step_due;
  logic [7:0]  sustain;

  assign period   = step_period(st, adsr, PERIOD_SHIFT);
  assign cnt_inc  = 33'(cnt) + 33'd1;
  assign step_due = cnt_inc >= {1'b0, period};
  assign sustain  = {adsr[7:4], adsr[7:4]};

  always_comb begin
    st_next  = st;
    cnt_next = cnt;
    lvl_next = lvl;
    if (test) begin
      st_next  = EnvIdle;
      cnt_next = '0;
      lvl_next = '0;
    end else if (gate && !prev_gate) begin
      st_next  = EnvAttack;
      cnt_next = '0;
    end else if (!gate && prev_gate) begin
      st_next  = EnvRelease;
      cnt_next = '0;
    end else begin
      case (st)
        EnvIdle: lvl_next = '0;
        EnvAttack: begin
          if (lvl == 8'hff) begin
            st_next  = EnvDecay;
            cnt_next = '0;
          end else if (step_due) begin
            cnt_next = '0;
            lvl_next = lvl + 8'd1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        EnvDecay: begin
          if (lvl <= sustain) begin
            st_next = EnvSustain;
          end else if (step_due) begin
            cnt_next = '0;
            lvl_next = lvl - 8'd1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        EnvSustain: ;
        EnvRelease: begin
          if (lvl == 8'h00) begin
            st_next = EnvIdle;
          end else if (step_due) begin
            cnt_next = '0;
            lvl_next = lvl - 8'd1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          st_next  = EnvIdle;
          cnt_next = '0;
          lvl_next = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/env_scheduler.sv
// Round-robin envelope scheduler: one tick services every voice, one voice per cycle,
// through a single shared step datapath.
module env_scheduler
  import env_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 3,
  parameter int unsigned CNT_W        = 25,
  parameter int unsigned PERIOD_SHIFT = 0
) (
  input logic            clk,
  input logic            rst,
  env_scheduler_if.slave bus
);

  localparam int unsigned SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  sched_state_t      sched_q, sched_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              pending_q, pending_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              wr_en;
  logic              last_slot;

  env_state_t       st_q   [NUM_VOICES];
  logic [CNT_W-1:0] cnt_q  [NUM_VOICES];
  logic [7:0]       lvl_q  [NUM_VOICES];
  logic             gate_q [NUM_VOICES];

  logic [7:0]       cur_ctrl;
  logic [15:0]      cur_adsr;
  env_state_t       nxt_st;
  logic [CNT_W-1:0] nxt_cnt;
  logic [7:0]       nxt_lvl;
  logic             unused_ctrl_bits;

  assign cur_ctrl         = bus.control_v[slot_q*8 +: 8];
  assign cur_adsr         = bus.adsr_v[slot_q*16 +: 16];
  assign unused_ctrl_bits = ^{cur_ctrl[7:4], cur_ctrl[2:1]};
  assign last_slot        = (slot_q == SLOT_W'(NUM_VOICES - 1));

  env_step #(
    .CNT_W       (CNT_W),
    .PERIOD_SHIFT(PERIOD_SHIFT)
  ) u_step (
    .st       (st_q[slot_q]),
    .cnt      (cnt_q[slot_q]),
    .lvl      (lvl_q[slot_q]),
    .prev_gate(gate_q[slot_q]),
    .gate     (cur_ctrl[0]),
    .test     (cur_ctrl[3]),
    .adsr     (cur_adsr),
    .st_next  (nxt_st),
    .cnt_next (nxt_cnt),
    .lvl_next (nxt_lvl)
  );

  always_comb begin
    sched_d   = sched_q;
    slot_d    = slot_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    wr_en     = 1'b0;
    case (sched_q)
      SchedWait: begin
        if (bus.tick_en) begin
          sched_d = SchedService;
          slot_d  = '0;
        end
      end
      SchedService: begin
        wr_en = 1'b1;
        if (last_slot) begin
          // A tick on the final slot fills the pending slot and is consumed at once;
          // if pending was already full it is the one dropped.
          done_d    = 1'b1;
          slot_d    = '0;
          pending_d = 1'b0;
          overrun_d = bus.tick_en && pending_q;
          if (!(pending_q || bus.tick_en)) sched_d = SchedWait;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
          if (bus.tick_en) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
          end
        end
      end
      default: sched_d = SchedWait;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched_q   <= SchedWait;
      slot_q    <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sched_q   <= sched_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        st_q[k]   <= EnvIdle;
        cnt_q[k]  <= '0;
        lvl_q[k]  <= '0;
        gate_q[k] <= 1'b0;
      end
    end else if (wr_en) begin
      st_q[slot_q]   <= nxt_st;
      cnt_q[slot_q]  <= nxt_cnt;
      lvl_q[slot_q]  <= nxt_lvl;
      gate_q[slot_q] <= cur_ctrl[0];
    end
  end

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_vol
    assign bus.vol_out[k*8 +: 8] = lvl_q[k];
  end

  assign bus.busy       = (sched_q == SchedService);
  assign bus.round_done = done_q;
  assign bus.overrun    = overrun_q;

endmodule
